// File: rtl/register_write_sequencer.sv
// Turns an I2C write byte stream (pointer, then data) into register file writes, with ALL_LED broadcast expansion.
// Write strobe appears the cycle after a data byte is accepted; a broadcast takes 34 cycles (17 writes, each followed by an idle cycle).
// byte_ready_o drops while a write or broadcast is in progress, so the byte source must hold byte_valid_i/byte_i.
module register_write_sequencer #(
  parameter logic [7:0] LED_BASE     = 8'h06,
  parameter int         NUM_LEDS     = 16,
  parameter logic [7:0] LAST_LED_REG = 8'h45,
  parameter logic [7:0] ALL_LED_BASE = 8'hFA,
  parameter logic [7:0] PRESCALE_REG = 8'hFE
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       byte_ready_o,
  input  logic       auto_inc_i,
  input  logic       sleep_i,
  output logic [7:0] write_register_id_o,
  output logic [7:0] write_register_value_o,
  output logic       write_enable_o,
  output logic [7:0] pointer_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {S_PTR, S_DATA, S_GAP, S_WRITE, S_BCAST} state_t;

  // Broadcast runs one write plus one idle cycle for each LED and for the ALL_LED register itself.
  localparam int BCAST_LAST = 2 * (NUM_LEDS + 1) - 1;

  state_t     state, state_nxt;
  logic [7:0] ptr;
  logic [7:0] data_q;
  logic       ai_q;
  logic       pending_start;
  logic [5:0] bcnt;

  logic       accept;
  logic       ptr_is_all_led;
  logic       drop;
  logic       bcast_last;
  logic       go_ptr;
  logic [7:0] ptr_inc;
  logic [7:0] led_off;

  assign byte_ready_o   = !rst_i && (state == S_PTR || state == S_DATA || state == S_GAP);
  assign accept         = byte_valid_i && byte_ready_o;
  assign ptr_is_all_led = (ptr >= ALL_LED_BASE) && (ptr <= ALL_LED_BASE + 8'd3);
  assign drop           = (ptr > LAST_LED_REG && ptr < ALL_LED_BASE) || (ptr == 8'hFF) ||
                          (ptr == PRESCALE_REG && !sleep_i);
  assign bcast_last     = (bcnt == 6'(BCAST_LAST));
  assign go_ptr         = pending_start || start_i;
  // Auto-increment wraps at the last LED register and at the top of the map.
  assign ptr_inc        = (ptr == LAST_LED_REG || ptr == 8'hFF) ? 8'h00 : ptr + 8'd1;
  // Each LED channel spans four registers; bcnt[5:1] is the channel index during the broadcast.
  assign led_off        = {1'b0, bcnt[5:1], 2'b00};
  assign pointer_o      = ptr;
  assign busy_o         = (state == S_BCAST);

  // State, pointer, latched data and broadcast counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_PTR;
      ptr           <= 8'h00;
      data_q        <= 8'h00;
      ai_q          <= 1'b0;
      pending_start <= 1'b0;
      bcnt          <= 6'd0;
    end else begin
      state <= state_nxt;
      bcnt  <= (state == S_BCAST) ? bcnt + 6'd1 : 6'd0;
      // A start seen mid-broadcast is remembered until the broadcast finishes.
      pending_start <= (state == S_BCAST) && !bcast_last && (pending_start || start_i);
      case (state)
        S_PTR: begin
          if (accept) ptr <= byte_i;
        end
        S_DATA, S_GAP: begin
          if (accept) begin
            if (start_i) begin
              ptr <= byte_i;
            end else begin
              data_q <= byte_i;
              ai_q   <= auto_inc_i;
            end
          end
        end
        S_WRITE: begin
          if (ai_q) ptr <= ptr_inc;
        end
        S_BCAST: begin
          if (bcast_last && ai_q) ptr <= ptr_inc;
        end
        default: ;
      endcase
    end
  end

  // Next-state selection and register file write port drive.
  always_comb begin
    state_nxt              = state;
    write_enable_o         = 1'b0;
    write_register_id_o    = 8'h00;
    write_register_value_o = 8'h00;
    case (state)
      S_PTR: begin
        if (accept) state_nxt = S_DATA;
      end
      S_DATA, S_GAP: begin
        if (accept && start_i)   state_nxt = S_DATA;
        else if (start_i)        state_nxt = S_PTR;
        else if (accept)         state_nxt = ptr_is_all_led ? S_BCAST : S_WRITE;
        else                     state_nxt = S_DATA;
      end
      S_WRITE: begin
        state_nxt = go_ptr ? S_PTR : S_GAP;
        if (!drop) begin
          write_enable_o         = 1'b1;
          write_register_id_o    = ptr;
          write_register_value_o = data_q;
        end
      end
      S_BCAST: begin
        if (bcast_last) state_nxt = go_ptr ? S_PTR : S_GAP;
        if (!bcnt[0]) begin
          write_enable_o         = 1'b1;
          write_register_value_o = data_q;
          if (bcnt[5:1] < 5'(NUM_LEDS))
            write_register_id_o = LED_BASE + (ptr - ALL_LED_BASE) + led_off;
          else
            write_register_id_o = ptr;
        end
      end
      default: state_nxt = S_PTR;
    endcase
  end

endmodule

// File: tb/tb_register_write_sequencer.sv
// Directed bench with a write scoreboard: expected writes are queued as bytes are driven, popped as write strobes appear.
module tb_register_write_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       byte_valid_i = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic       byte_ready_o;
  logic       auto_inc_i = 1'b1;
  logic       sleep_i = 1'b0;
  logic [7:0] write_register_id_o;
  logic [7:0] write_register_value_o;
  logic       write_enable_o;
  logic [7:0] pointer_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  logic prev_we = 1'b0;
  logic [15:0] sb[$];

  register_write_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .auto_inc_i(auto_inc_i), .sleep_i(sleep_i),
    .write_register_id_o(write_register_id_o),
    .write_register_value_o(write_register_value_o),
    .write_enable_o(write_enable_o), .pointer_o(pointer_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] id, input logic [7:0] val);
    sb.push_back({id, val});
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_i = b;
    while (!byte_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check("byte_accept_timeout", 32'(n), 0);
    @(posedge clk_i);
    #1 byte_valid_i = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk_i);
  endtask

  // Scoreboard monitor: every write strobe must be isolated and match the oldest queued write.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_we <= 1'b0;
    end else begin
      if (write_enable_o) begin
        wr_count++;
        check("we_isolated", {31'd0, prev_we}, 0);
        if (sb.size() == 0) begin
          check("unexpected_write", {16'd0, write_register_id_o, write_register_value_o}, 32'hFFFF_FFFF);
        end else begin
          check("write_id_val", {16'd0, write_register_id_o, write_register_value_o}, {16'd0, sb.pop_front()});
        end
      end
      prev_we <= write_enable_o;
    end
  end

  initial begin
    int base;
    int busy_cycles;
    int ready_bad;
    int n;

    // Reset state.
    #12;
    check("rst_we", {31'd0, write_enable_o}, 0);
    check("rst_ptr", {24'd0, pointer_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_ready_forced", {31'd0, byte_ready_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_rst", {31'd0, byte_ready_o}, 1);

    // Sequential writes with auto-increment.
    auto_inc_i = 1'b1;
    pulse_start();
    send_byte(8'h06);
    push_wr(8'h06, 8'h11); send_byte(8'h11);
    push_wr(8'h07, 8'h22); send_byte(8'h22);
    push_wr(8'h08, 8'h33); send_byte(8'h33);
    push_wr(8'h09, 8'h44); send_byte(8'h44);
    settle();
    check("seq_ptr", {24'd0, pointer_o}, 32'h0A);
    check("seq_sb_empty", 32'(sb.size()), 0);

    // Wrap at last LED register, then no auto-increment.
    pulse_start();
    send_byte(8'h45);
    push_wr(8'h45, 8'hAA); send_byte(8'hAA);
    push_wr(8'h00, 8'hBB); send_byte(8'hBB);
    settle();
    check("wrap_ptr", {24'd0, pointer_o}, 32'h01);
    auto_inc_i = 1'b0;
    pulse_start();
    send_byte(8'h45);
    push_wr(8'h45, 8'hAA); send_byte(8'hAA);
    push_wr(8'h45, 8'hBB); send_byte(8'hBB);
    settle();
    check("noai_ptr", {24'd0, pointer_o}, 32'h45);
    check("wrap_sb_empty", 32'(sb.size()), 0);

    // PRE_SCALE lock and reserved drop.
    auto_inc_i = 1'b1;
    sleep_i = 1'b0;
    base = wr_count;
    pulse_start();
    send_byte(8'hFE);
    send_byte(8'h1E);
    settle();
    check("prescale_awake_drop", 32'(wr_count - base), 0);
    check("prescale_drop_ptr", {24'd0, pointer_o}, 32'hFF);
    sleep_i = 1'b1;
    pulse_start();
    send_byte(8'hFE);
    push_wr(8'hFE, 8'h1E); send_byte(8'h1E);
    settle();
    check("prescale_asleep_ptr", {24'd0, pointer_o}, 32'hFF);
    sleep_i = 1'b0;
    base = wr_count;
    pulse_start();
    send_byte(8'h50);
    send_byte(8'h77);
    settle();
    check("reserved_drop", 32'(wr_count - base), 0);
    check("reserved_ptr", {24'd0, pointer_o}, 32'h51);
    check("drop_sb_empty", 32'(sb.size()), 0);

    // Broadcast from ALL_LED_OFF_L.
    base = wr_count;
    pulse_start();
    send_byte(8'hFC);
    for (int i = 0; i < 16; i++) push_wr(8'(8'h08 + 4 * i), 8'h99);
    push_wr(8'hFC, 8'h99);
    send_byte(8'h99);
    busy_cycles = 0;
    ready_bad = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk_i);
      n++;
      if (!busy_o) break;
      busy_cycles++;
      if (byte_ready_o) ready_bad++;
    end
    check("bcast_busy_cycles", 32'(busy_cycles), 34);
    check("bcast_ready_low", 32'(ready_bad), 0);
    check("bcast_ready_after", {31'd0, byte_ready_o}, 1);
    settle();
    check("bcast_writes", 32'(wr_count - base), 17);
    check("bcast_ptr", {24'd0, pointer_o}, 32'hFD);
    check("bcast_sb_empty", 32'(sb.size()), 0);

    // start_i during a broadcast: broadcast completes, next byte is a pointer.
    base = wr_count;
    pulse_start();
    send_byte(8'hFA);
    for (int i = 0; i < 16; i++) push_wr(8'(8'h06 + 4 * i), 8'h55);
    push_wr(8'hFA, 8'h55);
    send_byte(8'h55);
    repeat (10) @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("pend_busy_drop", {31'd0, busy_o}, 0);
    send_byte(8'h10);
    push_wr(8'h10, 8'h77); send_byte(8'h77);
    settle();
    check("pend_writes", 32'(wr_count - base), 18);
    check("pend_ptr", {24'd0, pointer_o}, 32'h11);
    check("pend_sb_empty", 32'(sb.size()), 0);

    // Reset during a broadcast aborts it.
    base = wr_count;
    pulse_start();
    send_byte(8'hFB);
    push_wr(8'h07, 8'h33);
    push_wr(8'h0B, 8'h33);
    push_wr(8'h0F, 8'h33);
    send_byte(8'h33);
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("rst_mid_we", {31'd0, write_enable_o}, 0);
    check("rst_mid_ptr", {24'd0, pointer_o}, 0);
    check("rst_mid_busy", {31'd0, busy_o}, 0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    check("rst_abort_writes", 32'(wr_count - base), 3);
    check("rst_sb_empty", 32'(sb.size()), 0);
    send_byte(8'h20);
    push_wr(8'h20, 8'h5A); send_byte(8'h5A);
    settle();
    check("post_rst_ptr", {24'd0, pointer_o}, 32'h21);
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
